// File: rtl/cnt_attr_sched.sv
// Round-robin scheduler feeding a shared peak-tracking register with a programmable decay timer.
// Optional macro CNT_ATTR_SCHED_SAT_EN makes the decay saturate at zero instead of wrapping.
module cnt_attr_sched #(
    parameter int NREQ      = 4,
    parameter int W         = 16,
    parameter int DECAY_DIV = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [W-1:0]            peak,
    output logic [$clog2(NREQ)-1:0] peak_owner,
    output logic                    peak_vld,
    output logic                    decay_pulse
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(DECAY_DIV);

    logic [IW-1:0] r_rrPtr;
    logic          r_stgVld;
    logic [W-1:0]  r_stgData;
    logic [IW-1:0] r_stgIdx;
    logic [W-1:0]  r_peak;
    logic [IW-1:0] r_peakOwner;
    logic          r_peakVld;
    logic          r_decayPulse;
    logic [TW-1:0] r_timer;

    logic [W-1:0]    w_lane [NREQ];
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_grantIdx;
    logic [IW-1:0]   w_cand;
    logic            w_found;
    logic            w_handshake;
    logic            w_tick;
    logic            w_load;
    logic [W-1:0]    w_decayed;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign w_lane[g] = req_data[g*W +: W];
    end

    // Search starts one past the last winner so every lane gets a turn.
    always_comb begin
        w_grant    = '0;
        w_grantIdx = '0;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_rrPtr) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found         = 1'b1;
                w_grant[w_cand] = 1'b1;
                w_grantIdx      = w_cand;
            end
        end
    end

    assign w_handshake = reset && enable && w_found;
    assign req_ready   = w_handshake ? w_grant : '0;

    assign w_tick = enable && (r_timer == TW'(DECAY_DIV - 1));
    assign w_load = r_stgVld && (r_stgData > r_peak);

`ifdef CNT_ATTR_SCHED_SAT_EN
    assign w_decayed = (r_peak == '0) ? '0 : r_peak - 1'b1;
`else
    assign w_decayed = r_peak - 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rrPtr   <= IW'(NREQ - 1);
            r_stgVld  <= 1'b0;
            r_stgData <= '0;
            r_stgIdx  <= '0;
        end else begin
            r_stgVld <= w_handshake;
            if (w_handshake) begin
                r_rrPtr   <= w_grantIdx;
                r_stgData <= w_lane[w_grantIdx];
                r_stgIdx  <= w_grantIdx;
            end
        end
    end

    // A load on a tick edge takes priority; the timer wraps regardless.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_peak       <= '0;
            r_peakOwner  <= '0;
            r_peakVld    <= 1'b0;
            r_decayPulse <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_decayPulse <= w_tick;
            if (enable) begin
                r_timer <= w_tick ? '0 : r_timer + 1'b1;
            end
            if (w_load) begin
                r_peak      <= r_stgData;
                r_peakOwner <= r_stgIdx;
                r_peakVld   <= 1'b1;
            end else if (w_tick) begin
                r_peak <= w_decayed;
            end
        end
    end

    assign peak        = r_peak;
    assign peak_owner  = r_peakOwner;
    assign peak_vld    = r_peakVld;
    assign decay_pulse = r_decayPulse;

endmodule

// File: tb/tb_cnt_attr_sched.sv
// Scoreboard bench for cnt_attr_sched: a per-edge behavioural model queues expected state and grants,
// and a negedge monitor compares them against the DUT.
module tb_cnt_attr_sched;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int DIV  = 8;
    localparam int HALF = 5;
    localparam int unsigned MASK = (1 << W) - 1;

    typedef struct {
        int unsigned peak;
        int unsigned owner;
        bit          vld;
        bit          pulse;
    } state_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    enable = 1'b0;
    logic [NREQ-1:0]         reqValid = '0;
    logic [NREQ*W-1:0]       reqData = '0;
    logic [NREQ-1:0]         reqReady;
    logic [W-1:0]            peak;
    logic [$clog2(NREQ)-1:0] peakOwner;
    logic                    peakVld;
    logic                    decayPulse;

    state_t          stateQ[$];
    logic [NREQ-1:0] grantQ[$];
    int              checks = 0;
    int              errors = 0;
    bit              monOn = 1'b0;
    int              laneCount[NREQ];

    int          mRr, mStgIdx, mTimer;
    int unsigned mStgData, mPeak, mOwner;
    bit          mStgVld, mVld, mPulse;
    bit                pEn;
    logic [NREQ-1:0]   pValid;
    logic [NREQ*W-1:0] pData;

    cnt_attr_sched #(.NREQ(NREQ), .W(W), .DECAY_DIV(DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .req_valid  (reqValid),
        .req_data   (reqData),
        .req_ready  (reqReady),
        .peak       (peak),
        .peak_owner (peakOwner),
        .peak_vld   (peakVld),
        .decay_pulse(decayPulse)
    );

    always #HALF clock = ~clock;

    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int pickLane(input int rr, input logic [NREQ-1:0] v, input bit en);
        if (!en) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*W-1:0] laneData(input int lane, input int unsigned val);
        logic [NREQ*W-1:0] r;
        r = '0;
        r[lane*W +: W] = W'(val);
        return r;
    endfunction

    task automatic resetModel();
        mRr = NREQ - 1; mStgVld = 0; mStgData = 0; mStgIdx = 0;
        mPeak = 0; mOwner = 0; mVld = 0; mPulse = 0; mTimer = 0;
        pEn = 0; pValid = '0; pData = '0;
        enable = 1'b0; reqValid = '0; reqData = '0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held during the previous cycle.
    task automatic modelEdge();
        int g;
        bit tick, load;
        tick = pEn && (mTimer == DIV - 1);
        load = mStgVld && (mStgData > mPeak);
        if (load) begin
            mPeak = mStgData; mOwner = mStgIdx; mVld = 1;
        end else if (tick) begin
`ifdef CNT_ATTR_SCHED_SAT_EN
            mPeak = (mPeak == 0) ? 0 : mPeak - 1;
`else
            mPeak = (mPeak + MASK) & MASK;
`endif
        end
        mPulse = tick;
        if (pEn) mTimer = (mTimer + 1) % DIV;
        g = pickLane(mRr, pValid, pEn);
        mStgVld = (g >= 0);
        if (g >= 0) begin
            mStgData = int'(pData[g*W +: W]); mStgIdx = g; mRr = g;
        end
    endtask

    task automatic applyStimulus(input bit en, input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] d);
        int g;
        state_t s;
        logic [NREQ-1:0] oh;
        @(posedge clock);
        #1;
        modelEdge();
        s = '{peak: mPeak, owner: mOwner, vld: mVld, pulse: mPulse};
        stateQ.push_back(s);
        enable = en; reqValid = v; reqData = d;
        pEn = en; pValid = v; pData = d;
        g = pickLane(mRr, v, en);
        if (g >= 0) begin
            oh = '0;
            oh[g] = 1'b1;
            grantQ.push_back(oh);
        end
        monOn = 1'b1;
    endtask

    // Asserts reset between a capture edge and the following update edge.
    task automatic doReset();
        @(posedge clock);
        #2;
        monOn = 1'b0;
        reset = 1'b0;
        enable = 1'b1;
        reqValid = '1;
        #1;
        checkOutput("rst_ready", reqReady, 0);
        checkOutput("rst_peak", peak, 0);
        checkOutput("rst_vld", peakVld, 0);
        checkOutput("rst_owner", peakOwner, 0);
        checkOutput("rst_pulse", decayPulse, 0);
        resetModel();
        @(negedge clock) reset = 1'b1;
    endtask

    always @(negedge clock) begin
        if (monOn) begin
            state_t e;
            if (stateQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL state_queue: got empty queue, expected an entry");
            end else begin
                e = stateQ.pop_front();
                checkOutput("peak", peak, e.peak);
                checkOutput("peak_owner", peakOwner, e.owner);
                checkOutput("peak_vld", peakVld, e.vld);
                checkOutput("decay_pulse", decayPulse, e.pulse);
            end
            if (|reqReady) begin
                for (int i = 0; i < NREQ; i++) laneCount[i] += int'(reqReady[i]);
                if (grantQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL grant: got 0x%0h, expected no grant", reqReady);
                end else begin
                    checkOutput("grant", reqReady, grantQ.pop_front());
                end
            end
        end
    end

    initial begin
        resetModel();
        repeat (3) @(posedge clock);
        #1;
        enable = 1'b1;
        reqValid = '1;
        #1;
        checkOutput("init_ready", reqReady, 0);
        checkOutput("init_peak", peak, 0);
        checkOutput("init_vld", peakVld, 0);
        checkOutput("init_owner", peakOwner, 0);
        checkOutput("init_pulse", decayPulse, 0);
        enable = 1'b0;
        reqValid = '0;
        @(negedge clock) reset = 1'b1;

        $display("[TB] first load and equal/smaller samples");
        applyStimulus(1, 4'b0001, laneData(0, 16'h0100));
        applyStimulus(1, 4'b0000, '0);
        applyStimulus(1, 4'b0100, laneData(2, 16'h0100));
        applyStimulus(1, 4'b0100, laneData(2, 16'h00FF));
        applyStimulus(1, 4'b0100, laneData(2, 16'h0101));
        repeat (3) applyStimulus(1, 4'b0000, '0);

        $display("[TB] round-robin fairness");
        applyStimulus(1, 4'b1000, laneData(3, 16'h0001));
        applyStimulus(1, 4'b0000, '0);
        for (int i = 0; i < NREQ; i++) laneCount[i] = 0;
        for (int c = 0; c < 8; c++) begin
            logic [NREQ*W-1:0] d;
            for (int i = 0; i < NREQ; i++) d[i*W +: W] = W'($urandom);
            applyStimulus(1, '1, d);
        end
        applyStimulus(1, 4'b0000, '0);
        for (int i = 0; i < NREQ; i++) checkOutput($sformatf("lane%0d_grants", i), laneCount[i], 2);

        $display("[TB] reset with a sample in flight, then decay through zero");
        applyStimulus(1, 4'b0010, laneData(1, 16'h0500));
        doReset();
        applyStimulus(1, 4'b0000, '0);
        applyStimulus(1, 4'b0011, laneData(0, 16'h0003) | laneData(1, 16'h0002));
        repeat (40) applyStimulus(1, 4'b0000, '0);

        $display("[TB] load on the terminal-count edge");
        applyStimulus(1, 4'b0000, '0);
        doReset();
        applyStimulus(1, 4'b0001, laneData(0, 16'h0010));
        for (int c = 0; c < 2 * DIV && mTimer != DIV - 3; c++) applyStimulus(1, 4'b0000, '0);
        checkOutput("timer_align", mTimer, DIV - 3);
        applyStimulus(1, 4'b1000, laneData(3, 16'h0200));
        repeat (3) applyStimulus(1, 4'b0000, '0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            logic [NREQ*W-1:0] d;
            for (int i = 0; i < NREQ; i++)
                d[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 48));
            applyStimulus($urandom_range(0, 4) != 0, NREQ'($urandom), d);
            if (c == 200) begin
                applyStimulus(1, 4'b0000, '0);
                doReset();
            end
        end
        applyStimulus(1, 4'b0000, '0);

        @(negedge clock);
        #1;
        monOn = 1'b0;
        checkOutput("state_queue_left", stateQ.size(), 0);
        checkOutput("grant_queue_left", grantQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_attr_sched.md
# cnt_attr_sched

Round-robin scheduler and controller for a shared peak-tracking decay counter. Up to NREQ requesters offer W-bit samples through valid/ready handshakes. The block grants one per cycle and pipelines the winner into the counter. A sample strictly greater than the current peak loads it. Otherwise a programmable decay timer decrements the peak. It sits between producer lanes and the single peak register they share.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, sample and peak width
- DECAY_DIV, 8, enabled cycles per decay tick (≥2)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  global run; 0 freezes arbitration and the decay timer
- req_valid  in  NREQ  per-requester sample valid
- req_data  in  NREQ*W  packed samples; lane i = bits [i*W+W-1 : i*W]
- req_ready  out  NREQ  one-hot grant (combinational)
- peak  out  W  current peak value (registered)
- peak_owner  out  $clog2(NREQ)  index of the requester that last loaded peak
- peak_vld  out  1  set after the first load
- decay_pulse  out  1  one-cycle pulse when a decay tick fires

## Operation
- Arbitration:
  - req_ready[i]=1 iff enable=1, req_valid[i]=1, and i is the first valid lane after rr_ptr in ascending wrap order.
  - A handshake occurs on valid&ready.
  - On a handshake, rr_ptr takes the granted index.
  - With no valid lanes, req_ready=0 and rr_ptr holds.
- Stage register: a handshake captures {data, index} into stg_data/stg_idx and sets stg_vld. Otherwise stg_vld clears. The stage is consumed every cycle, so the pipeline never stalls.
- Update stage, evaluated each cycle stg_vld=1:
  - stg_data > peak (unsigned, strict): peak←stg_data, peak_owner←stg_idx, peak_vld←1.
  - Equal or smaller: no load; the sample is dropped.
- Decay timer:
  - Counts 0..DECAY_DIV-1 while enable=1, then wraps.
  - At terminal count, decay_pulse=1 for one cycle.
  - If no load happens that cycle, peak←peak-1; peak_owner is unchanged.
- Decrement arithmetic is mod 2^W, so 0 wraps to all-ones. The SAT macro below changes this.
- Simultaneous load and decay tick: the load wins, decay is skipped, and the timer still wraps normally.
- enable=0:
  - No new grants; the timer holds its value; decay_pulse=0.
  - A sample already in the stage is still applied in the following cycle.
- The state machine is implicit: the stage is EMPTY or FULL, and it is FULL exactly one cycle after each handshake.

## Timing
- Reset values:
  - peak=0, peak_owner=0, peak_vld=0, decay_pulse=0, stg_vld=0, timer=0.
  - rr_ptr=NREQ-1, so lane 0 has first priority.
  - req_ready=0 while reset is asserted.
- Reset assertion mid-operation clears all state immediately. Any in-flight stage sample is discarded.
- Latency:
  - Handshake at edge t; stage holds the sample during cycle t..t+1.
  - peak updates at edge t+1 and is visible from that cycle on.
  - Accept-to-peak latency is 2 edges.
- Throughput: one accepted sample per cycle when enable=1.
- decay_pulse is registered. It is high in the cycle after the timer reaches DECAY_DIV-1, in the same cycle the decremented peak appears.

## Configuration
- CNT_ATTR_SCHED_SAT_EN:
  - Defined: decay saturates, so peak=0 stays 0 on a tick, and decay_pulse still fires.
  - Undefined: peak wraps 0→2^W-1 on a tick (mod 2^W), with peak_owner and peak_vld unchanged.

## Test plan
- Reset release, enable=1, lane 0 offers 0x0100 at edge 1 → req_ready=0001; peak=0x0100, owner=0, peak_vld=1 after edge 2.
- All 4 lanes valid for 8 cycles with rr_ptr=3 → grants in order 0,1,2,3,0,1,2,3; each lane exactly 2 handshakes.
- peak=0x0100; lane 2 offers 0x0100, then 0x00FF → no load for either; lane 2 then offers 0x0101 → peak=0x0101, owner=2.
- No requests, DECAY_DIV=8, peak=0x0003 → decay_pulse every 8th cycle; peak 3→2→1→0. The next tick gives 0xFFFF without the macro, or stays 0 with CNT_ATTR_SCHED_SAT_EN.
- Stage sample 0x0200 > peak 0x0010 arrives on the terminal-count cycle → peak=0x0200, no decrement, decay_pulse=1, timer wraps to 0.
- Handshake on lane 1, then reset asserted before the update edge → peak=0, peak_vld=0, stg_vld=0; after release lane 0 wins first.
